// File: rtl/genram2_arbiter.sv
// rtl/genram2_arbiter.sv - two-port round-robin arbiter in front of a single-port RAM
module genram2_arbiter #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          req0_valid,
   input  logic          req0_rw,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ready,
   output logic          req0_rvalid,
   output logic [DW-1:0] req0_rdata,

   input  logic          req1_valid,
   input  logic          req1_rw,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ready,
   output logic          req1_rvalid,
   output logic [DW-1:0] req1_rdata,

   output logic [AW-1:0] ram_addr,
   output logic          ram_rw,
   output logic [DW-1:0] ram_data_in,
   input  logic [DW-1:0] ram_data_out
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]    state;
   logic          last_grant;   // port number granted most recently
   logic          lat_rw;
   logic          lat_port;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;

   logic          grant0;
   logic          grant1;
   logic          accept;

   // Round-robin winner: on a tie the port not granted last time wins
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
   end

   // Ready only in IDLE and only for the winner; held low while reset is asserted
   always_comb begin
      req0_ready = rst_n && (state == S_IDLE) && grant0;
      req1_ready = rst_n && (state == S_IDLE) && grant1;
      accept     = req0_ready || req1_ready;
   end

   // RAM side: the latched request stays on addr/data_in; rw is a write only during ACCESS
   always_comb begin
      ram_addr    = lat_addr;
      ram_data_in = lat_wdata;
      ram_rw      = (state == S_ACCESS) ? lat_rw : 1'b1;
   end

   // Control FSM: latch the winning request, run one RAM cycle, optionally collect read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         lat_rw     <= 1'b1;
         lat_port   <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_rw     <= req1_ready ? req1_rw    : req0_rw;
                  lat_addr   <= req1_ready ? req1_addr  : req0_addr;
                  lat_wdata  <= req1_ready ? req1_wdata : req0_wdata;
                  lat_port   <= req1_ready;
                  last_grant <= req1_ready;
                  state      <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               state <= lat_rw ? S_RESP : S_IDLE;
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Read return: capture RAM output at the end of RESP into the owning port, pulse rvalid once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req0_rvalid <= 1'b0;
         req1_rvalid <= 1'b0;
         req0_rdata  <= '0;
         req1_rdata  <= '0;
      end else begin
         req0_rvalid <= 1'b0;
         req1_rvalid <= 1'b0;
         if (state == S_RESP) begin
            if (lat_port) begin
               req1_rdata  <= ram_data_out;
               req1_rvalid <= 1'b1;
            end else begin
               req0_rdata  <= ram_data_out;
               req0_rvalid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_genram2_arbiter.sv
// tb/tb_genram2_arbiter.sv - scoreboard bench for genram2_arbiter
module tb_genram2_arbiter;

   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req0_rw = 1'b1;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req0_ready, req0_rvalid;
   logic [DW-1:0] req0_rdata;
   logic          req1_valid = 1'b0, req1_rw = 1'b1;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          req1_ready, req1_rvalid;
   logic [DW-1:0] req1_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_rw;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_dout = '0;

   logic [DW-1:0] mem [0:15];
   logic          mem_init = 1'b0;
   int            cyc = 0;
   int            n_checks = 0;
   int            n_pass = 0;

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
   typedef struct { logic [DW-1:0] data; int cyc; } rd_t;

   wr_t wq[$];
   rd_t rq0[$];
   rd_t rq1[$];
   int  gq[$];

   genram2_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
      .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_data_in(ram_data_in), .ram_data_out(ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous single-port RAM model, preloaded with 0x1000_0000 + address
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + DW'(i);
         mem_init <= 1'b1;
      end else if (!ram_rw) begin
         mem[ram_addr] <= ram_data_in;
      end else begin
         ram_dout <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: got an event expected none", name);
   endtask

   // monitor: pops expectations whenever the DUT grants, writes RAM or returns read data
   always @(negedge clk) begin
      wr_t w;
      rd_t r;
      int  g;
      if (req0_ready || req1_ready) begin
         check("ready_exclusive", 64'(req0_ready && req1_ready), 64'd0);
         if (gq.size() == 0) fail_now("grant_unexpected");
         else begin
            g = gq.pop_front();
            check("grant_port", 64'(req1_ready), 64'(g));
         end
      end
      if (!ram_rw) begin
         if (wq.size() == 0) fail_now("ram_write_unexpected");
         else begin
            w = wq.pop_front();
            check("wr_addr", 64'(ram_addr), 64'(w.addr));
            check("wr_data", 64'(ram_data_in), 64'(w.data));
            check("wr_cycle", 64'(cyc), 64'(w.cyc));
         end
      end
      if (req0_rvalid) begin
         if (rq0.size() == 0) fail_now("rvalid0_unexpected");
         else begin
            r = rq0.pop_front();
            check("rdata0", 64'(req0_rdata), 64'(r.data));
            check("rvalid0_cycle", 64'(cyc), 64'(r.cyc));
         end
      end
      if (req1_rvalid) begin
         if (rq1.size() == 0) fail_now("rvalid1_unexpected");
         else begin
            r = rq1.pop_front();
            check("rdata1", 64'(req1_rdata), 64'(r.data));
            check("rvalid1_cycle", 64'(cyc), 64'(r.cyc));
         end
      end
   end

   // raise a request, wait for ready, queue the expected RAM write or read return, drop valid
   task automatic issue(input int p, input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input bit exp_rsp);
      bit got = 1'b0;
      @(posedge clk); #1;
      if (p == 0) begin
         req0_valid = 1'b1; req0_rw = rw; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = 1'b1; req1_rw = rw; req1_addr = a; req1_wdata = d;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) got = 1'b1;
      end
      if (!got) fail_now("ready_timeout");
      else if (!rw) wq.push_back('{a, d, cyc + 1});
      else if (exp_rsp) begin
         if (p == 0) rq0.push_back('{exp_rd, cyc + 3});
         else        rq1.push_back('{exp_rd, cyc + 3});
      end
      @(posedge clk); #1;
      if (p == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values, ready suppressed while in reset
      repeat (2) @(negedge clk);
      req0_valid = 1'b1;
      #1;
      check("reset_ready0", 64'(req0_ready), 64'd0);
      check("reset_ready1", 64'(req1_ready), 64'd0);
      check("reset_rvalid0", 64'(req0_rvalid), 64'd0);
      check("reset_rvalid1", 64'(req1_rvalid), 64'd0);
      check("reset_rdata0", 64'(req0_rdata), 64'd0);
      check("reset_rdata1", 64'(req1_rdata), 64'd0);
      check("reset_ram_addr", 64'(ram_addr), 64'd0);
      check("reset_ram_rw", 64'(ram_rw), 64'd1);
      check("reset_ram_data_in", 64'(ram_data_in), 64'd0);
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // both ports hold reads: grants alternate p0, p1, p0, p1
      gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
      fork
         begin
            issue(0, 1'b1, 4'd1, '0, 32'h1000_0001, 1'b1);
            issue(0, 1'b1, 4'd1, '0, 32'h1000_0001, 1'b1);
         end
         begin
            issue(1, 1'b1, 4'd2, '0, 32'h1000_0002, 1'b1);
            issue(1, 1'b1, 4'd2, '0, 32'h1000_0002, 1'b1);
         end
      join

      // port 1 alone is granted every time
      gq.push_back(1); gq.push_back(1); gq.push_back(1);
      issue(1, 1'b0, 4'd4, 32'h4444_4444, '0, 1'b1);
      issue(1, 1'b1, 4'd4, '0, 32'h4444_4444, 1'b1);
      issue(1, 1'b1, 4'd2, '0, 32'h1000_0002, 1'b1);

      // port 0 write then read back addr 3
      gq.push_back(0); gq.push_back(0);
      issue(0, 1'b0, 4'd3, 32'hA5A5_A5A5, '0, 1'b1);
      issue(0, 1'b1, 4'd3, '0, 32'hA5A5_A5A5, 1'b1);

      // top address, all ones; port 1 rdata must not move
      gq.push_back(0); gq.push_back(0);
      issue(0, 1'b0, 4'd15, 32'hFFFF_FFFF, '0, 1'b1);
      issue(0, 1'b1, 4'd15, '0, 32'hFFFF_FFFF, 1'b1);
      repeat (4) @(negedge clk);
      check("rdata0_hold", 64'(req0_rdata), 64'h0000_0000_FFFF_FFFF);
      check("rdata1_untouched", 64'(req1_rdata), 64'h0000_0000_1000_0002);

      // port 0 pulses a write during port 1 ACCESS and drops it before IDLE
      gq.push_back(1);
      fork
         issue(1, 1'b1, 4'd5, '0, 32'h1000_0005, 1'b1);
         begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
               @(negedge clk);
               if (req1_ready) seen = 1'b1;
            end
            if (!seen) fail_now("pulse_sync_timeout");
            @(posedge clk); #1;
            req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 4'd7; req0_wdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            req0_valid = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      check("pulse_no_write", 64'(mem[7]), 64'h0000_0000_1000_0007);

      // reset asserted during RESP of a port 1 read
      gq.push_back(1);
      issue(1, 1'b1, 4'd9, '0, '0, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midreset_ram_rw", 64'(ram_rw), 64'd1);
      check("midreset_ram_addr", 64'(ram_addr), 64'd0);
      check("midreset_rvalid1", 64'(req1_rvalid), 64'd0);
      check("midreset_rdata0", 64'(req0_rdata), 64'd0);
      repeat (3) @(negedge clk);
      check("midreset_rvalid1_later", 64'(req1_rvalid), 64'd0);
      rst_n = 1'b1;

      // after reset port 0 wins the first tie again
      gq.push_back(0); gq.push_back(1);
      fork
         issue(0, 1'b1, 4'd3, '0, 32'hA5A5_A5A5, 1'b1);
         issue(1, 1'b1, 4'd15, '0, 32'hFFFF_FFFF, 1'b1);
      join

      repeat (6) @(negedge clk);
      check("grants_drained", 64'(gq.size()), 64'd0);
      check("writes_drained", 64'(wq.size()), 64'd0);
      check("reads0_drained", 64'(rq0.size()), 64'd0);
      check("reads1_drained", 64'(rq1.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
